// File: rtl/uart_tx_parity_framer.sv
// uart_tx_parity_framer: serialises a word as start, LSB-first data, optional parity
// and 1 or 2 stop bits, with an internal baud divider and a valid/ready input.
module uart_tx_parity_framer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [2:0]            parity_mode,
    input  logic                  two_stop,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  parity_bit
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  parity_bit_q, parity_bit_d;
    logic                  tick, accept;

    assign tick   = cnt_q == LAST;
    assign accept = state_q == IDLE && tx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            two_stop_q   <= 1'b0;
            parity_bit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            two_stop_q   <= two_stop_d;
            parity_bit_q <= parity_bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tx_valid ? START : IDLE;
            START:   state_d = tick ? DATA : START;
            DATA:    if (tick && idx_q == IDX_LAST) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = tick ? STOP : PARITY;
            STOP:    if (tick && idx_q == IDX_W'(two_stop_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d        = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        // idx counts data bits in DATA and stop periods in STOP; cleared on every state change
        idx_d        = (state_d != state_q) ? '0 : (tick ? idx_q + 1'b1 : idx_q);
        data_d       = accept ? tx_data : data_q;
        par_en_d     = accept ? (parity_mode inside {[3'd1:3'd4]}) : par_en_q;
        two_stop_d   = accept ? two_stop : two_stop_q;
        parity_bit_d = accept ? (parity_mode == 3'd1 ? ^tx_data :
                                 parity_mode == 3'd2 ? ~^tx_data :
                                 parity_mode == 3'd3) : parity_bit_q;
    end

    always_comb begin
        tx_ready   = state_q == IDLE;
        busy       = state_q != IDLE;
        parity_bit = parity_bit_q;
        tx_out     = state_q == START  ? 1'b0 :
                     state_q == DATA   ? data_q[idx_q] :
                     state_q == PARITY ? parity_bit_q : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_parity_framer.sv
// tb_uart_tx_parity_framer: scoreboard bench; frames predicted from bit lists at acceptance,
// checked cycle-by-cycle by an independent line monitor.
module tb_uart_tx_parity_framer;
    localparam int CPB = 4;

    typedef struct {
        logic [63:0] w;
        int          len;
        logic        pb;
        int          st;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0, two_stop = 1'b0;
    logic [2:0] parity_mode = '0;
    logic       tx_ready, tx_out, busy, parity_bit;

    logic [6:0] tx_data7 = '0;
    logic       tx_valid7 = 1'b0, two_stop7 = 1'b0;
    logic [2:0] parity_mode7 = '0;
    logic       tx_ready7, tx_out7, busy7, parity_bit7;

    int   n_chk = 0, n_fail = 0, cyc_n = 0, left = 0, n_acc = 0;
    exp_t q[$];

    uart_tx_parity_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .parity_mode(parity_mode), .two_stop(two_stop), .tx_out(tx_out), .busy(busy),
        .parity_bit(parity_bit));

    uart_tx_parity_framer #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB)) u_dut7 (
        .clk(clk), .rst(rst), .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(tx_ready7),
        .parity_mode(parity_mode7), .two_stop(two_stop7), .tx_out(tx_out7), .busy(busy7),
        .parity_bit(parity_bit7));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Reference: list the line bits of a frame, then stretch each to CPB clocks.
    function automatic exp_t model(input int dw, input logic [8:0] d, input logic [2:0] m,
                                   input logic ts);
        exp_t e;
        logic b[$];
        int   ones;
        ones = $countones(d & 9'((1 << dw) - 1));
        e.pb = (m == 3'd1) ? (ones % 2 == 1) : (m == 3'd2) ? (ones % 2 == 0) : (m == 3'd3);
        b.push_back(1'b0);
        for (int i = 0; i < dw; i++) b.push_back(d[i]);
        if (m >= 3'd1 && m <= 3'd4) b.push_back(e.pb);
        b.push_back(1'b1);
        if (ts) b.push_back(1'b1);
        e.len = b.size() * CPB;
        e.w   = '0;
        for (int c = 0; c < e.len; c++) e.w[c] = b[c / CPB];
        e.st = 0;
        return e;
    endfunction

    // One clock of the main driver; tracks expected readiness independently of the DUT.
    task automatic cyc();
        int   nl;
        exp_t e;
        chk("tx_ready", tx_ready, left == 0);
        chk("busy", busy, left != 0);
        nl = left > 0 ? left - 1 : 0;
        if (rst) nl = 0;
        else if (tx_valid && left == 0) begin
            e    = model(8, {1'b0, tx_data}, parity_mode, two_stop);
            e.st = cyc_n + 1;
            q.push_back(e);
            nl = e.len;
            n_acc++;
        end
        @(posedge clk);
        #1;
        left = nl;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] m, input logic ts);
        tx_valid = 1'b0;
        for (int k = 0; k < 200 && left != 0; k++) cyc();
        tx_data = d;
        parity_mode = m;
        two_stop = ts;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
    endtask

    initial begin
        exp_t        cur;
        logic [63:0] act;
        int          n;
        bit          in_frame, end_chk;
        in_frame = 0;
        end_chk  = 0;
        n        = 0;
        act      = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                in_frame = 0;
                end_chk  = 0;
            end else if (in_frame) begin
                act[n] = tx_out;
                n++;
                if (n == cur.len) begin
                    chk("frame", act, cur.w);
                    chk("parity_bit", parity_bit, cur.pb);
                    in_frame = 0;
                    end_chk  = 1;
                end
            end else begin
                if (end_chk) begin
                    chk("frame_end", {tx_out, tx_ready, busy}, 3'b110);
                    end_chk = 0;
                end
                if (tx_out === 1'b0) begin
                    chk("start_pending", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        chk("start_cycle", cyc_n, cur.st);
                        act      = '0;
                        n        = 1;
                        in_frame = 1;
                    end
                end
            end
        end
    end

    initial begin
        exp_t        e7;
        logic [63:0] w7;
        int          a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {tx_out, tx_ready, busy, parity_bit}, 4'b1100);
        chk("rst_state7", {tx_out7, tx_ready7, busy7, parity_bit7}, 4'b1100);
        rst = 1'b0;

        send(8'hA5, 3'd1, 1'b0);
        send(8'hA5, 3'd2, 1'b0);
        send(8'hA5, 3'd3, 1'b0);
        send(8'hA5, 3'd4, 1'b0);
        send(8'hA5, 3'd0, 1'b0);
        send(8'hA5, 3'd7, 1'b1);

        // back-to-back with valid held high
        tx_valid = 1'b0;
        for (int k = 0; k < 200 && left != 0; k++) cyc();
        tx_data = 8'h00;
        parity_mode = 3'd1;
        two_stop = 1'b0;
        tx_valid = 1'b1;
        cyc();
        tx_data = 8'hFF;
        a = n_acc;
        for (int k = 0; k < 200 && n_acc == a; k++) cyc();
        chk("b2b_accepted", n_acc, a + 1);
        tx_valid = 1'b0;

        // reset during data bit 3
        send(8'h3C, 3'd1, 1'b0);
        repeat (17) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst", {tx_out, busy, tx_ready}, 3'b101);
        send(8'h5A, 3'd2, 1'b1);

        // 7-bit instance
        for (int k = 0; k < 200 && left != 0; k++) cyc();
        e7 = model(7, 9'h07F, 3'd2, 1'b1);
        tx_data7 = 7'h7F;
        parity_mode7 = 3'd2;
        two_stop7 = 1'b1;
        tx_valid7 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid7 = 1'b0;
        tx_data7 = 7'h00;
        parity_mode7 = 3'd1;
        two_stop7 = 1'b0;
        w7 = '0;
        for (int c = 0; c < e7.len; c++) begin
            @(negedge clk);
            w7[c] = tx_out7;
        end
        chk("frame7", w7, e7.w);
        chk("frame7_len", e7.len, 44);
        chk("parity_bit7", parity_bit7, e7.pb);
        @(negedge clk);
        chk("frame7_end", {tx_out7, tx_ready7, busy7}, 3'b110);

        // random traffic, inputs re-randomised every clock including mid-frame
        for (int i = 0; i < 3000; i++) begin
            tx_valid = $urandom_range(0, 3) != 0;
            tx_data = 8'($urandom);
            parity_mode = 3'($urandom);
            two_stop = 1'($urandom);
            cyc();
        end
        tx_valid = 1'b0;
        for (int k = 0; k < 200 && left != 0; k++) cyc();
        repeat (3) cyc();
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
